// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment scanner with dead time,
// per-digit blanking and optional leading-zero suppression.
module seg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 0,
  parameter int LZ_SUPPRESS = 0,
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [IW-1:0]           digit_idx
);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dpc_q, dpc_d;
  logic                  blk_q, blk_d;
  logic                  fresh_q, fresh_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  wrap;
  logic                  last;
  logic                  capture;
  logic                  dead;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blk;
  logic                  sel_sup;
  logic [NUM_DIGITS-1:0] hi_zero;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign wrap = (pcnt_q == PW'(REFRESH_DIV - 1));
  assign last = (idx_q == IW'(NUM_DIGITS - 1));

  // fresh_q makes the first enabled edge after reset load digit 0
  always_comb begin
    pcnt_d  = pcnt_q;
    idx_d   = idx_q;
    fresh_d = fresh_q;
    capture = 1'b0;
    if (en) begin
      fresh_d = 1'b0;
      capture = fresh_q;
      if (wrap) begin
        pcnt_d  = '0;
        idx_d   = last ? '0 : idx_q + 1'b1;
        capture = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // hi_zero[i]: nibbles i..top all zero and no dp request among them
  always_comb begin
    logic run;
    run = 1'b1;
    hi_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (digits[4*i +: 4] == 4'h0) & ~dp_in[i];
      hi_zero[i] = run;
    end
  end

  always_comb begin
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    sel_blk = 1'b1;
    sel_sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        sel_nib = digits[4*i +: 4];
        sel_dp  = dp_in[i];
        sel_blk = blank[i];
        sel_sup = (LZ_SUPPRESS != 0) && (i > 0) && hi_zero[i];
      end
    end
  end

  always_comb begin
    nib_d = nib_q;
    dpc_d = dpc_q;
    blk_d = blk_q;
    if (capture) begin
      nib_d = sel_nib;
      dpc_d = sel_dp;
      blk_d = sel_blk | sel_sup;
    end
  end

  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign dead = (pcnt_d < PW'(DEAD_CYCLES));
    end else begin : g_nodead
      assign dead = 1'b0;
    end
  endgenerate

  // outputs follow the state being loaded, so they align with pcnt
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !dead && !blk_d) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_d != IW'(i));
      end
      seg_d = hex7(nib_d);
      dp_d  = ~dpc_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q  <= '0;
      idx_q   <= '0;
      nib_q   <= 4'h0;
      dpc_q   <= 1'b0;
      blk_q   <= 1'b1;
      fresh_q <= 1'b1;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      dpc_q   <= dpc_d;
      blk_q   <= blk_d;
      fresh_q <= fresh_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: three configurations driven
// together, checked against a slot-arithmetic reference model.
module tb_seg_scan_mux;

  localparam int R = 4;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits_a = '0, digits_b = '0;
  logic [3:0]  dp_a = '0, dp_b = '0, blank_a = '0, blank_b = '0;
  logic [31:0] digits_c = '0;
  logic [7:0]  dp_c = '0, blank_c = '0;

  logic [3:0] an_a, an_b;
  logic [7:0] an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dpo_a, dpo_b, dpo_c;
  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;

  int n_chk = 0;
  int n_fail = 0;

  exp_t qa[$], qb[$], qc[$];

  // reference model state: enabled edges since reset and per-DUT slot data
  int n = 0;
  int  s_nib [3];
  bit  s_dp  [3];
  bit  s_blk [3];

  logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(R),
                 .DEAD_CYCLES(1), .LZ_SUPPRESS(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .digits(digits_a),
    .dp_in(dp_a), .blank(blank_a), .an(an_a), .seg(seg_a),
    .dp(dpo_a), .digit_idx(idx_a));

  seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(R),
                 .DEAD_CYCLES(1), .LZ_SUPPRESS(1)) u_b (
    .clk(clk), .reset(reset), .en(en), .digits(digits_b),
    .dp_in(dp_b), .blank(blank_b), .an(an_b), .seg(seg_b),
    .dp(dpo_b), .digit_idx(idx_b));

  seg_scan_mux #(.NUM_DIGITS(8), .REFRESH_DIV(R),
                 .DEAD_CYCLES(0), .LZ_SUPPRESS(0)) u_c (
    .clk(clk), .reset(reset), .en(en), .digits(digits_c),
    .dp_in(dp_c), .blank(blank_c), .an(an_c), .seg(seg_c),
    .dp(dpo_c), .digit_idx(idx_c));

  function automatic void snap(input int d, input logic [31:0] dg,
                               input logic [7:0] dpi, input logic [7:0] bl,
                               input bit lz, input int i);
    s_nib[d] = int'((dg >> (4 * i)) & 32'hF);
    s_dp[d]  = dpi[i];
    s_blk[d] = bl[i];
    if (lz && i > 0 && (dg >> (4 * i)) == 0 && (dpi >> i) == 0)
      s_blk[d] = 1'b1;
  endfunction

  function automatic exp_t model(input int d, input int nd, input int dead);
    exp_t e;
    int pc;
    pc = n % R;
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.idx = 3'((n / R) % nd);
    if (en && !reset && n > 0 && pc >= dead && !s_blk[d]) begin
      e.an  = ~(8'd1 << e.idx);
      e.seg = SEG[s_nib[d]];
      e.dp  = ~s_dp[d];
    end
    return e;
  endfunction

  // advance the model over the coming edge and queue the expected outputs
  task automatic cyc();
    if (reset) begin
      n = 0;
      for (int d = 0; d < 3; d++) begin
        s_nib[d] = 0; s_dp[d] = 0; s_blk[d] = 1;
      end
    end else if (en) begin
      n++;
      if (n % R == 0 || n == 1) begin
        snap(0, {16'h0, digits_a}, {4'h0, dp_a}, {4'h0, blank_a}, 0, (n / R) % 4);
        snap(1, {16'h0, digits_b}, {4'h0, dp_b}, {4'h0, blank_b}, 1, (n / R) % 4);
        snap(2, digits_c, dp_c, blank_c, 0, (n / R) % 8);
      end
    end
    qa.push_back(model(0, 4, 1));
    qb.push_back(model(1, 4, 1));
    qc.push_back(model(2, 8, 0));
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string nm, input logic [7:0] an,
                     input logic [6:0] seg, input logic dpv,
                     input logic [2:0] idx, input exp_t e,
                     input logic [7:0] mask);
    n_chk++;
    if ((an & mask) != (e.an & mask) || seg !== e.seg ||
        dpv !== e.dp || idx !== e.idx) begin
      n_fail++;
      $display("FAIL %s t=%0t: got an=%h seg=%b dp=%b idx=%0d, want an=%h seg=%b dp=%b idx=%0d",
               nm, $time, an & mask, seg, dpv, idx,
               e.an & mask, e.seg, e.dp, e.idx);
    end
  endtask

  always @(posedge clk) begin
    exp_t ea, eb, ec;
    #1;
    if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      ec = qc.pop_front();
      chk("dut_a", {4'hF, an_a}, seg_a, dpo_a, {1'b0, idx_a}, ea, 8'h0F);
      chk("dut_b", {4'hF, an_b}, seg_b, dpo_b, {1'b0, idx_b}, eb, 8'h0F);
      chk("dut_c", an_c, seg_c, dpo_c, idx_c, ec, 8'hFF);
    end
  end

  task automatic async_check(input string nm, input logic [7:0] an,
                             input logic [6:0] seg, input logic dpv,
                             input logic [2:0] idx);
    n_chk++;
    if (an !== 8'hFF || seg !== 7'h7F || dpv !== 1'b1 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL async_%s: got an=%h seg=%b dp=%b idx=%0d, want an=ff seg=1111111 dp=1 idx=0",
               nm, an, seg, dpv, idx);
    end
  endtask

  initial begin
    int guard;
    cyc();
    reset = 1'b0;
    cyc();

    // scan sequence, leading-zero blanking
    digits_a = 16'h12AF;
    digits_b = 16'h0050;
    digits_c = 32'h8421_C3E7;
    en = 1'b1;
    repeat (24) cyc();
    dp_b = 4'b0100;
    repeat (16) cyc();

    // async reset landing between edges in slot 3
    guard = 0;
    while (!((n / R) % 4 == 3 && n % R == 1) && guard < 40) begin
      cyc();
      guard++;
    end
    reset = 1'b1;
    #1;
    async_check("a", {4'hF, an_a}, seg_a, dpo_a, {1'b0, idx_a});
    async_check("b", {4'hF, an_b}, seg_b, dpo_b, {1'b0, idx_b});
    async_check("c", an_c, seg_c, dpo_c, idx_c);
    cyc();
    reset = 1'b0;

    // mid-slot data change
    digits_a = 16'h0001;
    repeat (2) cyc();
    digits_a = 16'h0008;
    repeat (20) cyc();

    // enable dropped mid-slot 2
    guard = 0;
    while (!((n / R) % 4 == 2 && n % R == 2) && guard < 40) begin
      cyc();
      guard++;
    end
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (12) cyc();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        digits_a = 16'($urandom);
        digits_b = 16'($urandom) >> (4 * $urandom_range(0, 4));
        digits_c = $urandom;
        dp_a = 4'($urandom);
        dp_b = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        dp_c = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        blank_a = 4'($urandom) & 4'($urandom);
        blank_b = 4'($urandom) & 4'($urandom);
      end
      cyc();
    end
    reset = 1'b0;
    en = 1'b1;
    repeat (4) cyc();

    n_chk++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", qa.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
